// File: rtl/shared_counter_arb.sv
// Round-robin arbiter that serialises inc/dec/load/clear requests onto one shared counter.
// Optional COUNTER_ARB_SATURATE_EN: inc/dec clamp at the bounds instead of wrapping.
module shared_counter_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [2*NUM_REQ-1:0]         req_op,
  input  logic [WIDTH*NUM_REQ-1:0]     req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [WIDTH-1:0]             count_out,
  output logic                         grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         ovf_pulse,
  output logic                         busy
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t            state_r;
  logic [IDW-1:0]    last_grant_r;
  logic [IDW-1:0]    grant_id_r;
  logic              grant_valid_r;
  logic [WIDTH-1:0]  count_r;
  logic              ovf_r;

  logic              win_found_s;
  logic [IDW-1:0]    win_id_s;
  logic [1:0]        op_s;
  logic [WIDTH-1:0]  data_s;
  logic              exec_fire_s;
  logic [WIDTH-1:0]  next_count_s;
  logic              next_ovf_s;
  logic [NUM_REQ-1:0] ready_s;

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin : rr_search
    int idx;
    idx         = 0;
    win_found_s = 1'b0;
    win_id_s    = {IDW{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_r) + k) % NUM_REQ;
      if (!win_found_s && req_valid[idx]) begin
        win_found_s = 1'b1;
        win_id_s    = IDW'(idx);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Select the granted requester's opcode/data and decide whether the op executes.
  always_comb begin
    op_s        = req_op[2*grant_id_r +: 2];
    data_s      = req_data[WIDTH*grant_id_r +: WIDTH];
    exec_fire_s = (state_r == EXEC) && req_valid[grant_id_r];
  end

  // Counter datapath; the bound check drives both the wrap/clamp and ovf.
  always_comb begin
    next_count_s = count_r;
    next_ovf_s   = 1'b0;
    case (op_s)
      2'b00: begin
        if (count_r == {WIDTH{1'b1}}) begin
`ifdef COUNTER_ARB_SATURATE_EN
          next_count_s = {WIDTH{1'b1}};
`else
          next_count_s = {WIDTH{1'b0}};
`endif
          next_ovf_s = 1'b1;
        end else begin
          next_count_s = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      2'b01: begin
        if (count_r == {WIDTH{1'b0}}) begin
`ifdef COUNTER_ARB_SATURATE_EN
          next_count_s = {WIDTH{1'b0}};
`else
          next_count_s = {WIDTH{1'b1}};
`endif
          next_ovf_s = 1'b1;
        end else begin
          next_count_s = count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      2'b10:   next_count_s = data_s;
      2'b11:   next_count_s = {WIDTH{1'b0}};
      default: next_count_s = count_r;
    endcase
  end

  // Completion strobe is combinational so the requester sees it in the EXEC cycle.
  always_comb begin
    ready_s = {NUM_REQ{1'b0}};
    if (exec_fire_s) begin
      ready_s[grant_id_r] = 1'b1;
    end else begin
      ready_s = {NUM_REQ{1'b0}};
    end
  end

  // Arbitration FSM with counter and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      last_grant_r  <= IDW'(NUM_REQ - 1);
      grant_id_r    <= {IDW{1'b0}};
      grant_valid_r <= 1'b0;
      count_r       <= {WIDTH{1'b0}};
      ovf_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ovf_r <= 1'b0;
          if (win_found_s) begin
            grant_id_r    <= win_id_s;
            grant_valid_r <= 1'b1;
            state_r       <= EXEC;
          end else begin
            grant_valid_r <= 1'b0;
            state_r       <= IDLE;
          end
        end
        EXEC: begin
          grant_valid_r <= 1'b0;
          state_r       <= IDLE;
          // An aborted grant leaves counter and rotation pointer untouched.
          if (exec_fire_s) begin
            count_r      <= next_count_s;
            ovf_r        <= next_ovf_s;
            last_grant_r <= grant_id_r;
          end else begin
            ovf_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          grant_valid_r <= 1'b0;
          ovf_r         <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = ready_s;
  assign count_out   = count_r;
  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;
  assign ovf_pulse   = ovf_r;
  assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_shared_counter_arb.sv
// Directed bench for shared_counter_arb: handshake timing, round-robin order, wrap/clamp, abort, reset.
module tb_shared_counter_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  count_out;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        ovf_pulse;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

`ifdef COUNTER_ARB_SATURATE_EN
  localparam logic [7:0] INC_TOP = 8'hFF;
  localparam logic [7:0] DEC_BOT = 8'h00;
`else
  localparam logic [7:0] INC_TOP = 8'h00;
  localparam logic [7:0] DEC_BOT = 8'hFF;
`endif

  shared_counter_arb #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready), .count_out(count_out), .grant_valid(grant_valid),
    .grant_id(grant_id), .ovf_pulse(ovf_pulse), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] d);
    req_op[2*i +: 2]   = op;
    req_data[8*i +: 8] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b0000; req_op = 8'h00; req_data = 32'h0;
    step(); step();
    n_vec++; if (count_out !== 8'h00)   begin n_bad++; $display("FAIL rst_count got %h want 00", count_out); end
    n_vec++; if (grant_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_gv got %b want 0", grant_valid); end
    n_vec++; if (grant_id !== 2'd0)     begin n_bad++; $display("FAIL rst_gid got %0d want 0", grant_id); end
    n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready got %b want 0000", req_ready); end
    n_vec++; if (ovf_pulse !== 1'b0)    begin n_bad++; $display("FAIL rst_ovf got %b want 0", ovf_pulse); end
    n_vec++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    set_req(0, 2'b00, 8'h00);
    req_valid = 4'b0001;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_vec++; if (grant_valid !== 1'b1)  begin n_bad++; $display("FAIL b2b_gv[%0d] got %b want 1", i, grant_valid); end
      n_vec++; if (grant_id !== 2'd0)     begin n_bad++; $display("FAIL b2b_gid[%0d] got %0d want 0", i, grant_id); end
      n_vec++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL b2b_ready[%0d] got %b want 0001", i, req_ready); end
      step();
      n_vec++; if (count_out !== 8'(i))   begin n_bad++; $display("FAIL b2b_count[%0d] got %h want %h", i, count_out, 8'(i)); end
      n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL b2b_idle_ready[%0d] got %b want 0000", i, req_ready); end
      n_vec++; if (ovf_pulse !== 1'b0)    begin n_bad++; $display("FAIL b2b_ovf[%0d] got %b want 0", i, ovf_pulse); end
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) set_req(r, 2'b00, 8'h00);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++; if (grant_id !== 2'(exp_order[i])) begin n_bad++; $display("FAIL rr_gid[%0d] got %0d want %0d", i, grant_id, exp_order[i]); end
      n_vec++; if (req_ready !== (4'b0001 << exp_order[i])) begin n_bad++; $display("FAIL rr_ready[%0d] got %b want %b", i, req_ready, 4'b0001 << exp_order[i]); end
      step();
      n_vec++; if (count_out !== 8'(i + 1)) begin n_bad++; $display("FAIL rr_count[%0d] got %h want %h", i, count_out, 8'(i + 1)); end
    end
    req_valid = 4'b0100;
    set_req(2, 2'b10, 8'hF0);
    step();
    n_vec++; if (grant_id !== 2'd2)     begin n_bad++; $display("FAIL rr_load_gid got %0d want 2", grant_id); end
    step();
    n_vec++; if (count_out !== 8'hF0)   begin n_bad++; $display("FAIL rr_load_count got %h want f0", count_out); end
    req_valid = 4'b0000;
  endtask

  task automatic test_wrap();
    set_req(3, 2'b10, 8'hFF);
    req_valid = 4'b1000;
    step();
    n_vec++; if (grant_id !== 2'd3)     begin n_bad++; $display("FAIL wrap_gid got %0d want 3", grant_id); end
    step();
    n_vec++; if (count_out !== 8'hFF)   begin n_bad++; $display("FAIL wrap_loadff got %h want ff", count_out); end
    n_vec++; if (ovf_pulse !== 1'b0)    begin n_bad++; $display("FAIL wrap_load_ovf got %b want 0", ovf_pulse); end
    set_req(3, 2'b00, 8'h00);
    step();
    n_vec++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL wrap_inc_ready got %b want 1000", req_ready); end
    step();
    n_vec++; if (count_out !== INC_TOP) begin n_bad++; $display("FAIL wrap_inc_count got %h want %h", count_out, INC_TOP); end
    n_vec++; if (ovf_pulse !== 1'b1)    begin n_bad++; $display("FAIL wrap_inc_ovf got %b want 1", ovf_pulse); end
    set_req(3, 2'b10, 8'h00);
    step();
    n_vec++; if (ovf_pulse !== 1'b0)    begin n_bad++; $display("FAIL wrap_ovf_len got %b want 0", ovf_pulse); end
    step();
    n_vec++; if (count_out !== 8'h00)   begin n_bad++; $display("FAIL wrap_load00 got %h want 00", count_out); end
    set_req(3, 2'b01, 8'h00);
    step(); step();
    n_vec++; if (count_out !== DEC_BOT) begin n_bad++; $display("FAIL wrap_dec_count got %h want %h", count_out, DEC_BOT); end
    n_vec++; if (ovf_pulse !== 1'b1)    begin n_bad++; $display("FAIL wrap_dec_ovf got %b want 1", ovf_pulse); end
    req_valid = 4'b0000;
    step();
    n_vec++; if (ovf_pulse !== 1'b0)    begin n_bad++; $display("FAIL wrap_dec_ovf_len got %b want 0", ovf_pulse); end
    n_vec++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL wrap_busy got %b want 0", busy); end
  endtask

  task automatic test_abort();
    set_req(1, 2'b10, 8'h10);
    req_valid = 4'b0010;
    step(); step();
    n_vec++; if (count_out !== 8'h10)   begin n_bad++; $display("FAIL ab_pre_count got %h want 10", count_out); end
    req_valid = 4'b0000;
    set_req(1, 2'b11, 8'h00);
    req_valid = 4'b0010;
    step();
    n_vec++; if (grant_valid !== 1'b1)  begin n_bad++; $display("FAIL ab_gv got %b want 1", grant_valid); end
    n_vec++; if (grant_id !== 2'd1)     begin n_bad++; $display("FAIL ab_gid got %0d want 1", grant_id); end
    req_valid = 4'b0000;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL ab_ready got %b want 0000", req_ready); end
    step();
    n_vec++; if (count_out !== 8'h10)   begin n_bad++; $display("FAIL ab_count got %h want 10", count_out); end
    n_vec++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL ab_busy got %b want 0", busy); end
    set_req(2, 2'b00, 8'h00);
    req_valid = 4'b0110;
    step();
    n_vec++; if (grant_id !== 2'd2)     begin n_bad++; $display("FAIL ab_next_gid got %0d want 2", grant_id); end
    n_vec++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL ab_next_ready got %b want 0100", req_ready); end
    step();
    n_vec++; if (count_out !== 8'h11)   begin n_bad++; $display("FAIL ab_next_count got %h want 11", count_out); end
    req_valid = 4'b0010;
    step();
    n_vec++; if (grant_id !== 2'd1)     begin n_bad++; $display("FAIL ab_retry_gid got %0d want 1", grant_id); end
    step();
    n_vec++; if (count_out !== 8'h00)   begin n_bad++; $display("FAIL ab_retry_count got %h want 00", count_out); end
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid_exec();
    set_req(3, 2'b10, 8'hAA);
    req_valid = 4'b1000;
    step(); step();
    n_vec++; if (count_out !== 8'hAA)   begin n_bad++; $display("FAIL rx_pre_count got %h want aa", count_out); end
    set_req(3, 2'b10, 8'h55);
    step();
    n_vec++; if (grant_valid !== 1'b1)  begin n_bad++; $display("FAIL rx_gv got %b want 1", grant_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (count_out !== 8'h00)   begin n_bad++; $display("FAIL rx_count got %h want 00", count_out); end
    n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rx_ready got %b want 0000", req_ready); end
    n_vec++; if (grant_valid !== 1'b0)  begin n_bad++; $display("FAIL rx_gv_clr got %b want 0", grant_valid); end
    n_vec++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL rx_busy got %b want 0", busy); end
    step();
    set_req(0, 2'b00, 8'h00);
    req_valid = 4'b1001;
    rst_n = 1'b1;
    step();
    n_vec++; if (grant_id !== 2'd0)     begin n_bad++; $display("FAIL rx_first_gid got %0d want 0", grant_id); end
    step();
    n_vec++; if (count_out !== 8'h01)   begin n_bad++; $display("FAIL rx_first_count got %h want 01", count_out); end
    req_valid = 4'b1000;
    step();
    n_vec++; if (grant_id !== 2'd3)     begin n_bad++; $display("FAIL rx_second_gid got %0d want 3", grant_id); end
    step();
    n_vec++; if (count_out !== 8'h55)   begin n_bad++; $display("FAIL rx_second_count got %h want 55", count_out); end
    req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_round_robin();
    test_wrap();
    test_abort();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
